// File: rtl/ser_tx_shifter.sv
// FIFO-buffered parallel-to-serial shifter; bits advance on the bit_en strobe.
// Define SER_PARITY_EN to append an odd-parity bit to every frame.
module ser_tx_shifter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 4,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_LVL  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   bit_en,
   output logic                   dout,
   output logic                   dout_valid,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
`ifdef SER_PARITY_EN
      PARITY,
`endif
      SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [IW-1:0]    sel_idx;
   logic             dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push, load;

   assign in_ready   = (count_q < CW'(DEPTH)) && !rst;
   assign busy       = (state_q != IDLE) || (count_q != '0);
   assign count      = count_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

   always_comb begin
      push    = in_valid && in_ready;
      load    = 1'b0;
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;

      case (state_q)
         IDLE: load = (count_q != '0);
         SHIFT: begin
            if (bit_en) begin
               if (idx_q == LAST_IDX) begin
`ifdef SER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = IDLE;
                  load    = (count_q != '0);
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
`ifdef SER_PARITY_EN
         PARITY: begin
            if (bit_en) begin
               state_d = IDLE;
               load    = (count_q != '0);
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      // A load overrides the IDLE fallback so back-to-back frames have no gap.
      if (load) begin
         state_d = SHIFT;
         word_d  = mem_q[rd_ptr_q];
         idx_d   = '0;
      end

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, load})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Output flops are computed from next-state so dout tracks the launched bit.
      sel_idx      = MSB_FIRST ? (LAST_IDX - idx_d) : idx_d;
      dout_d       = IDLE_LVL;
      dout_valid_d = 1'b0;
      case (state_d)
         SHIFT: begin
            dout_d       = word_d[sel_idx];
            dout_valid_d = 1'b1;
         end
`ifdef SER_PARITY_EN
         PARITY: begin
            dout_d       = ~^word_d;
            dout_valid_d = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         word_q       <= '0;
         idx_q        <= '0;
         dout_q       <= IDLE_LVL;
         dout_valid_q <= 1'b0;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         idx_q        <= idx_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_ser_tx_shifter.sv
// Self-checking bench for ser_tx_shifter: directed timing cases plus a random
// run scored against a queue of expected serial bits.
module tb_ser_tx_shifter;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
`ifdef SER_PARITY_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             bit_en;
   logic             dout;
   logic             dout_valid;
   logic             busy;
   logic [2:0]       count;

   int checks   = 0;
   int failures = 0;
   int push_cnt = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   ser_tx_shifter #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .MSB_FIRST(1'b1),
      .IDLE_LVL(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .bit_en(bit_en),
      .dout(dout),
      .dout_valid(dout_valid),
      .busy(busy),
      .count(count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Bit k of the serial frame for word w (MSB first, optional odd parity last).
   function automatic bit frame_bit(input logic [WIDTH-1:0] w, input int unsigned k);
      if (k >= WIDTH) return ~^w;
      return w[WIDTH-1-k];
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      in_valid = 1'b0;
      bit_en   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
         next_cycle();
      end
      check_eq("drain_idle", busy, 0);
      next_cycle();
   endtask

   // Scoreboard: queue each accepted word's frame, compare each consumed bit.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (dout_valid && bit_en) begin
            if (exp_q.size() == 0) check_eq("sb_extra_bit", exp_q.size(), 1);
            else check_eq("sb_bit", dout, exp_q.pop_front());
         end
         if (!dout_valid) check_eq("idle_level", dout, 1);
         check_eq("busy_rule", busy, (dout_valid || (count != 0)));
         check_eq("count_range", (count <= DEPTH), 1);
         if (in_valid && in_ready) begin
            push_cnt++;
            for (int unsigned k = 0; k < FRAME; k++) exp_q.push_back(frame_bit(in_data, k));
         end
      end
   end

   initial begin
      int base;
      int vcnt;
      logic [WIDTH-1:0] w;

      // Reset held two cycles with in_valid asserted.
      rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; bit_en = 1'b0;
      next_cycle();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("rst_in_ready", in_ready, 0);
         check_eq("rst_dout", dout, 1);
         check_eq("rst_dout_valid", dout_valid, 0);
         check_eq("rst_count", count, 0);
         check_eq("rst_busy", busy, 0);
         next_cycle();
      end
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check_eq("post_rst_ready", in_ready, 1);
      next_cycle();

      // Single word, bit_en always high: first bit two cycles after the push.
      w = 8'h55;
      in_valid = 1'b1; in_data = w; bit_en = 1'b1;
      @(negedge clk);
      check_eq("t2_ready", in_ready, 1);
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("t2_count_load", count, 1);
      check_eq("t2_valid_load", dout_valid, 0);
      for (int unsigned k = 0; k < FRAME; k++) begin
         next_cycle();
         @(negedge clk);
         check_eq("t2_valid", dout_valid, 1);
         check_eq("t2_bit", dout, frame_bit(w, k));
      end
      next_cycle();
      @(negedge clk);
      check_eq("t2_end_dout", dout, 1);
      check_eq("t2_end_valid", dout_valid, 0);
      check_eq("t2_end_busy", busy, 0);
      next_cycle();

      // Two words back to back: contiguous valid bits with no gap.
      in_valid = 1'b1; in_data = 8'h55; bit_en = 1'b1;
      next_cycle();
      in_data = 8'hAA;
      next_cycle();
      in_valid = 1'b0;
      for (int unsigned k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         check_eq("t3_valid", dout_valid, 1);
         check_eq("t3_bit", dout, frame_bit((k < FRAME) ? 8'h55 : 8'hAA, k % FRAME));
         next_cycle();
      end
      @(negedge clk);
      check_eq("t3_end_valid", dout_valid, 0);
      next_cycle();

      // Stalled shifter: capacity is DEPTH queued plus one in flight.
      wait_idle();
      bit_en = 1'b0; in_valid = 1'b1; base = push_cnt;
      for (int i = 0; i < 10; i++) begin
         in_data = WIDTH'($urandom);
         @(negedge clk);
         next_cycle();
      end
      check_eq("t4_accepted", push_cnt - base, DEPTH + 1);
      in_valid = 1'b0; bit_en = 1'b1;
      @(negedge clk);
      check_eq("t4_count_full", count, DEPTH);
      check_eq("t4_ready_full", in_ready, 0);
      for (int unsigned c = 1; c < FRAME; c++) begin
         next_cycle();
         @(negedge clk);
      end
      check_eq("t4_ready_before_load", in_ready, 0);
      next_cycle();
      @(negedge clk);
      check_eq("t4_ready_rise", in_ready, 1);
      check_eq("t4_count_after", count, DEPTH - 1);
      next_cycle();
      wait_idle();

      // bit_en every third cycle: each bit held three cycles.
      bit_en = 1'b0; in_valid = 1'b1; in_data = 8'hF0;
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      for (int unsigned k = 0; k < FRAME; k++) begin
         for (int ph = 0; ph < 3; ph++) begin
            bit_en = (ph == 2);
            @(negedge clk);
            check_eq("t5_valid", dout_valid, 1);
            check_eq("t5_bit", dout, frame_bit(8'hF0, k));
            next_cycle();
         end
      end
      bit_en = 1'b0;
      @(negedge clk);
      check_eq("t5_end_valid", dout_valid, 0);
      next_cycle();

      // Reset mid-word with two words queued discards everything.
      wait_idle();
      bit_en = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = WIDTH'($urandom);
         next_cycle();
      end
      in_valid = 1'b0; bit_en = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check_eq("t6_count_pre", count, 2);
      check_eq("t6_valid_pre", dout_valid, 1);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_eq("t6_dout", dout, 1);
      check_eq("t6_valid", dout_valid, 0);
      check_eq("t6_count", count, 0);
      vcnt = 0;
      for (int i = 0; i < 30; i++) begin
         next_cycle();
         @(negedge clk);
         if (dout_valid) vcnt++;
      end
      check_eq("t6_no_bits", vcnt, 0);
      next_cycle();

`ifdef SER_PARITY_EN
      // Odd parity of 8'h07 (three ones) is 0.
      wait_idle();
      in_valid = 1'b1; in_data = 8'h07; bit_en = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      for (int unsigned k = 0; k < WIDTH; k++) next_cycle();
      @(negedge clk);
      check_eq("par_valid", dout_valid, 1);
      check_eq("par_bit", dout, 0);
      next_cycle();
`endif

      // Random traffic scored by the bit queue.
      wait_idle();
      for (int i = 0; i < 3000; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         bit_en   = ($urandom_range(0, 9) < 4);
         in_data  = WIDTH'($urandom);
         next_cycle();
      end
      wait_idle();
      check_eq("sb_leftover", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
